// File: rtl/sifh_hist_builder.sv
// -----------------------------------------------------------------------------
// sifh_hist_builder
// Two-pass SiFH histogram builder for the dToF pipeline. A coarse pass bins
// the top NB timestamp bits per pixel and tracks each pixel's peak bin. A fine
// pass then bins 1-LSB timestamps inside a 2^NB-wide window placed around that
// coarse peak. One fine-peak result per pixel is streamed out on valid/ready.
//
// Ports
//   clk         clock
//   res         asynchronous active-low reset
//   in_valid    sample valid
//   in_ready    block accepts a sample (COARSE / FINE only)
//   in_data     timestamp, all-ones = no detection
//   peak_valid  result valid
//   peak_ready  result consumed
//   peak_pixel  pixel index of the current result
//   peak_tof    fine peak timestamp (window base + fine peak bin)
//   peak_count  fine peak bin count, 0 = no fine hit
//   frame_done  one-cycle pulse after the last result is accepted
//
// state  | meaning
// CLR_C  | clear all histogram bins before the coarse pass
// COARSE | accept samples, bin by top NB bits
// WIN    | compute each pixel's fine window base from its coarse peak
// CLR_F  | clear all histogram bins before the fine pass
// FINE   | accept samples, bin by offset inside the window
// OUT    | stream one result per pixel
// -----------------------------------------------------------------------------
module sifh_hist_builder #(
    parameter int NP           = 12,
    parameter int NB           = 6,
    parameter int PIXELS       = 4,
    parameter int DATA_PER_PIX = 2,
    parameter int ACQ_NUM      = 16,
    parameter int CNT_W        = 8,
    localparam int PIX_W       = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NP-1:0]    in_data,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic [PIX_W-1:0] peak_pixel,
    output logic [NP-1:0]    peak_tof,
    output logic [CNT_W-1:0] peak_count,
    output logic             frame_done
);

    localparam int NBINS  = PIXELS * (2 ** NB);
    localparam int ADDR_W = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam int DAT_W  = (DATA_PER_PIX > 1) ? $clog2(DATA_PER_PIX) : 1;
    localparam int ACQ_W  = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [NP-1:0]    ALL_ONES = '1;
    localparam logic [NP-1:0]    HALF     = NP'(1) << (NB - 1);
    localparam logic [NP-1:0]    LO_MAX   = ALL_ONES - (NP'(1) << NB);

    localparam logic [2:0] S_CLR_C  = 3'd0;
    localparam logic [2:0] S_COARSE = 3'd1;
    localparam logic [2:0] S_WIN    = 3'd2;
    localparam logic [2:0] S_CLR_F  = 3'd3;
    localparam logic [2:0] S_FINE   = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [DAT_W-1:0]  dat_q, dat_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [ACQ_W-1:0]  acq_q, acq_d;
    logic [PIX_W-1:0]  win_q, win_d;
    logic [PIX_W-1:0]  out_q, out_d;
    logic              frame_done_q, frame_done_d;

    logic [NP-1:0]     lo_q       [PIXELS];
    logic [NP-1:0]     lo_d       [PIXELS];
    logic [CNT_W-1:0]  peak_cnt_q [PIXELS];
    logic [CNT_W-1:0]  peak_cnt_d [PIXELS];
    logic [NB-1:0]     peak_bin_q [PIXELS];
    logic [NB-1:0]     peak_bin_d [PIXELS];

    // Read stage registers of the bin read-modify-write.
    logic              p1_en_q, p1_en_d;
    logic [ADDR_W-1:0] p1_addr_q, p1_addr_d;
    logic [PIX_W-1:0]  p1_pix_q, p1_pix_d;
    logic [NB-1:0]     p1_bin_q, p1_bin_d;
    logic [CNT_W-1:0]  p1_rd_q, p1_rd_d;

    logic [CNT_W-1:0]  mem_q [NBINS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [CNT_W-1:0]  mem_wd;

    logic              accept, is_nohit, bin_ok, last_sample, clearing;
    logic [NP-1:0]     cur_lo, fine_off;
    logic [NB-1:0]     bin_sel;
    logic [ADDR_W-1:0] acc_addr;
    logic [CNT_W-1:0]  wr_cnt, rd_fwd;

    function automatic logic [NP-1:0] win_lo(input logic [NB-1:0] c);
        logic [NP-1:0] ch;
        logic [NP-1:0] lo;
        ch = {c, {(NP-NB){1'b0}}};
        if (ch < HALF) lo = '0;
        else           lo = ch - HALF;
        if (lo > LO_MAX) lo = LO_MAX;
        return lo;
    endfunction

    assign clearing = (state_q == S_CLR_C) || (state_q == S_CLR_F);
    assign in_ready = (state_q == S_COARSE) || (state_q == S_FINE);
    assign accept   = in_valid && in_ready;
    assign is_nohit = (in_data == ALL_ONES);
    assign cur_lo   = lo_q[pix_q];
    assign fine_off = in_data - cur_lo;

    assign last_sample = (dat_q == DAT_W'(DATA_PER_PIX - 1)) &&
                         (pix_q == PIX_W'(PIXELS - 1)) &&
                         (acq_q == ACQ_W'(ACQ_NUM - 1));

    always_comb begin
        bin_ok  = 1'b0;
        bin_sel = in_data[NP-1 -: NB];
        if (state_q == S_COARSE) begin
            bin_ok = !is_nohit;
        end else begin
            // In-window means in_data >= lo and the offset fits in NB bits.
            bin_ok  = !is_nohit && (in_data >= cur_lo) && (fine_off[NP-1:NB] == '0);
            bin_sel = fine_off[NB-1:0];
        end
    end

    assign acc_addr = (ADDR_W'(pix_q) << NB) + ADDR_W'(bin_sel);
    assign wr_cnt   = (p1_rd_q == CNT_MAX) ? CNT_MAX : p1_rd_q + 1'b1;
    // The write for the previous sample lands this cycle; forward it so
    // back-to-back hits on one bin both count.
    assign rd_fwd   = (p1_en_q && (p1_addr_q == acc_addr)) ? wr_cnt : mem_q[acc_addr];

    always_comb begin
        mem_we = 1'b0;
        mem_wa = p1_addr_q;
        mem_wd = wr_cnt;
        if (clearing) begin
            mem_we = 1'b1;
            mem_wa = clr_q;
            mem_wd = '0;
        end else if (p1_en_q) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    // Strictly-greater update keeps the bin that reached a tied maximum first.
    always_comb begin
        peak_cnt_d = peak_cnt_q;
        peak_bin_d = peak_bin_q;
        if (clearing) begin
            for (int i = 0; i < PIXELS; i++) begin
                peak_cnt_d[i] = '0;
                peak_bin_d[i] = '0;
            end
        end else if (p1_en_q && (wr_cnt > peak_cnt_q[p1_pix_q])) begin
            peak_cnt_d[p1_pix_q] = wr_cnt;
            peak_bin_d[p1_pix_q] = p1_bin_q;
        end
    end

    // WIN reads the next-state peak so the final coarse write is included.
    always_comb begin
        lo_d = lo_q;
        if (state_q == S_WIN) lo_d[win_q] = win_lo(peak_bin_d[win_q]);
    end

    always_comb begin
        state_d      = state_q;
        clr_d        = clr_q;
        dat_d        = dat_q;
        pix_d        = pix_q;
        acq_d        = acq_q;
        win_d        = win_q;
        out_d        = out_q;
        frame_done_d = 1'b0;
        p1_en_d      = accept && bin_ok;
        p1_addr_d    = acc_addr;
        p1_pix_d     = pix_q;
        p1_bin_d     = bin_sel;
        p1_rd_d      = rd_fwd;
        case (state_q)
            S_CLR_C, S_CLR_F: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == ADDR_W'(NBINS - 1)) begin
                    clr_d   = '0;
                    state_d = (state_q == S_CLR_C) ? S_COARSE : S_FINE;
                end
            end
            S_COARSE, S_FINE: begin
                if (accept) begin
                    if (last_sample) begin
                        dat_d   = '0;
                        pix_d   = '0;
                        acq_d   = '0;
                        state_d = (state_q == S_COARSE) ? S_WIN : S_OUT;
                    end else if (dat_q != DAT_W'(DATA_PER_PIX - 1)) begin
                        dat_d = dat_q + 1'b1;
                    end else begin
                        dat_d = '0;
                        if (pix_q != PIX_W'(PIXELS - 1)) begin
                            pix_d = pix_q + 1'b1;
                        end else begin
                            pix_d = '0;
                            acq_d = acq_q + 1'b1;
                        end
                    end
                end
            end
            S_WIN: begin
                win_d = win_q + 1'b1;
                if (win_q == PIX_W'(PIXELS - 1)) begin
                    win_d   = '0;
                    state_d = S_CLR_F;
                end
            end
            S_OUT: begin
                if (peak_ready) begin
                    out_d = out_q + 1'b1;
                    if (out_q == PIX_W'(PIXELS - 1)) begin
                        out_d        = '0;
                        state_d      = S_CLR_C;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_CLR_C;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= S_CLR_C;
            clr_q        <= '0;
            dat_q        <= '0;
            pix_q        <= '0;
            acq_q        <= '0;
            win_q        <= '0;
            out_q        <= '0;
            frame_done_q <= 1'b0;
            p1_en_q      <= 1'b0;
            p1_addr_q    <= '0;
            p1_pix_q     <= '0;
            p1_bin_q     <= '0;
            p1_rd_q      <= '0;
            for (int i = 0; i < PIXELS; i++) begin
                lo_q[i]       <= '0;
                peak_cnt_q[i] <= '0;
                peak_bin_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            clr_q        <= clr_d;
            dat_q        <= dat_d;
            pix_q        <= pix_d;
            acq_q        <= acq_d;
            win_q        <= win_d;
            out_q        <= out_d;
            frame_done_q <= frame_done_d;
            p1_en_q      <= p1_en_d;
            p1_addr_q    <= p1_addr_d;
            p1_pix_q     <= p1_pix_d;
            p1_bin_q     <= p1_bin_d;
            p1_rd_q      <= p1_rd_d;
            lo_q         <= lo_d;
            peak_cnt_q   <= peak_cnt_d;
            peak_bin_q   <= peak_bin_d;
        end
    end

    // Peak values are read through the next-state path so the last fine write
    // is already visible in the first OUT cycle; nothing changes them after.
    assign peak_valid = (state_q == S_OUT);
    assign peak_pixel = out_q;
    assign peak_tof   = peak_valid ? lo_q[out_q] + NP'(peak_bin_d[out_q]) : '0;
    assign peak_count = peak_valid ? peak_cnt_d[out_q] : '0;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sifh_hist_builder.sv
module tb_sifh_hist_builder;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       peak_ready = 1'b1;
    logic       sel16 = 1'b0;

    logic       in_ready_a, peak_valid_a, frame_done_a;
    logic [0:0] peak_pixel_a;
    logic [7:0] peak_tof_a;
    logic [3:0] peak_count_a;
    logic       in_ready_b, peak_valid_b, frame_done_b;
    logic [0:0] peak_pixel_b;
    logic [7:0] peak_tof_b;
    logic [3:0] peak_count_b;

    logic       in_ready_m, peak_valid_m, frame_done_m;
    logic [0:0] peak_pixel_m;
    logic [7:0] peak_tof_m;
    logic [3:0] peak_count_m;

    always #5 clk = ~clk;

    sifh_hist_builder #(.NP(8), .NB(4), .PIXELS(2), .DATA_PER_PIX(2), .ACQ_NUM(4), .CNT_W(4)) dut (
        .clk(clk), .res(res),
        .in_valid(in_valid && !sel16), .in_ready(in_ready_a), .in_data(in_data),
        .peak_valid(peak_valid_a), .peak_ready(peak_ready && !sel16),
        .peak_pixel(peak_pixel_a), .peak_tof(peak_tof_a), .peak_count(peak_count_a),
        .frame_done(frame_done_a)
    );

    sifh_hist_builder #(.NP(8), .NB(4), .PIXELS(2), .DATA_PER_PIX(2), .ACQ_NUM(16), .CNT_W(4)) dut16 (
        .clk(clk), .res(res),
        .in_valid(in_valid && sel16), .in_ready(in_ready_b), .in_data(in_data),
        .peak_valid(peak_valid_b), .peak_ready(peak_ready && sel16),
        .peak_pixel(peak_pixel_b), .peak_tof(peak_tof_b), .peak_count(peak_count_b),
        .frame_done(frame_done_b)
    );

    assign in_ready_m   = sel16 ? in_ready_b   : in_ready_a;
    assign peak_valid_m = sel16 ? peak_valid_b : peak_valid_a;
    assign frame_done_m = sel16 ? frame_done_b : frame_done_a;
    assign peak_pixel_m = sel16 ? peak_pixel_b : peak_pixel_a;
    assign peak_tof_m   = sel16 ? peak_tof_b   : peak_tof_a;
    assign peak_count_m = sel16 ? peak_count_b : peak_count_a;

    typedef struct {
        int pix;
        int tof;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] samp [2][16][2][2];
    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Result monitor: pops the scoreboard on each accepted result.
    always @(negedge clk) begin
        if (res) begin
            if (peak_valid_m && peak_ready) begin
                chk("result_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("peak_pixel", int'(peak_pixel_m), e.pix);
                    chk("peak_tof",   int'(peak_tof_m),   e.tof);
                    chk("peak_count", int'(peak_count_m), e.cnt);
                end
            end
            if (frame_done_m) begin
                chk("done_after_last_result", exp_q.size(), 0);
                fd_cnt++;
            end
        end
    end

    task automatic fill(input int scen, input int acq_n);
        int b0, b1, v;
        b0 = $urandom_range(32, 200);
        b1 = $urandom_range(32, 200);
        for (int ps = 0; ps < 2; ps++)
            for (int a = 0; a < acq_n; a++)
                for (int p = 0; p < 2; p++)
                    for (int d = 0; d < 2; d++) begin
                        case (scen)
                            3: samp[ps][a][p][d] = (p == 1) ? 8'hFF :
                                                   (ps == 1 && a == 0 && d == 1) ? 8'h20 : 8'h03;
                            4: samp[ps][a][p][d] = (p == 0) ? 8'h77 : 8'hA5;
                            5: samp[ps][a][p][d] = (p == 1) ? 8'h80 : ((d == 0) ? 8'h31 : 8'h34);
                            7: begin
                                v = ((p == 0) ? b0 : b1) + $urandom_range(0, 12) - 6;
                                samp[ps][a][p][d] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'(v);
                            end
                            default: samp[ps][a][p][d] = (p == 0) ? 8'h5A : 8'h52;
                        endcase
                    end
    endtask

    // Reference: walk each pixel's samples in stream order, saturating at 15,
    // replacing the peak only on a strictly larger count.
    task automatic model(input int acq_n);
        int cnt [16];
        int pk, pb, s, b, lo;
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            foreach (cnt[i]) cnt[i] = 0;
            pk = 0; pb = 0;
            for (int a = 0; a < acq_n; a++)
                for (int d = 0; d < 2; d++) begin
                    s = int'(samp[0][a][p][d]);
                    if (s != 255) begin
                        b = s / 16;
                        if (cnt[b] < 15) cnt[b]++;
                        if (cnt[b] > pk) begin pk = cnt[b]; pb = b; end
                    end
                end
            lo = (pb * 16 < 8) ? 0 : pb * 16 - 8;
            if (lo > 239) lo = 239;
            foreach (cnt[i]) cnt[i] = 0;
            pk = 0; pb = 0;
            for (int a = 0; a < acq_n; a++)
                for (int d = 0; d < 2; d++) begin
                    s = int'(samp[1][a][p][d]);
                    if (s != 255 && s >= lo && s <= lo + 15) begin
                        b = s - lo;
                        if (cnt[b] < 15) cnt[b]++;
                        if (cnt[b] > pk) begin pk = cnt[b]; pb = b; end
                    end
                end
            e.pix = p; e.tof = lo + pb; e.cnt = pk;
            exp_q.push_back(e);
        end
    endtask

    // Holds in_valid high and advances only on accepted samples.
    task automatic drive(input int first, input int n, input int acq_n);
        int i, cyc, per, r, ps;
        logic acc;
        per = acq_n * 4;
        i = first; cyc = 0;
        while (i < first + n && cyc < 5000) begin
            @(negedge clk);
            ps = i / per; r = i % per;
            in_valid = 1'b1;
            in_data  = samp[ps][r / 4][(r / 2) % 2][r % 2];
            acc = in_ready_m;
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        #1 in_valid = 1'b0;
        if (cyc >= 5000) chk("drive_timeout", i, first + n);
    endtask

    task automatic run_frame(input int scen, input int acq_n, input bit hold);
        int fd0, cyc;
        logic [12:0] snap;
        bit stable;
        fill(scen, acq_n);
        model(acq_n);
        fd0 = fd_cnt;
        if (hold) peak_ready = 1'b0;
        drive(0, 2 * acq_n * 4, acq_n);
        if (hold) begin
            cyc = 0;
            @(negedge clk);
            while (!peak_valid_m && cyc < 200) begin @(negedge clk); cyc++; end
            chk("hold_valid_seen", int'(peak_valid_m), 1);
            snap = {peak_pixel_m, peak_tof_m, peak_count_m};
            stable = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (!peak_valid_m || {peak_pixel_m, peak_tof_m, peak_count_m} != snap) stable = 1'b0;
            end
            chk("hold_stable", int'(stable), 1);
            @(posedge clk);
            #1 peak_ready = 1'b1;
        end
        cyc = 0;
        while (fd_cnt == fd0 && cyc < 500) begin @(negedge clk); cyc++; end
        chk("frame_done_seen", fd_cnt - fd0, 1);
        @(negedge clk);
        chk("frame_done_one_cycle", int'(frame_done_m), 0);
    endtask

    initial begin
        int low;
        bit quiet;
        repeat (3) @(negedge clk);
        // Reset release with in_valid held: the clear phase must refuse samples.
        fill(2, 4);
        in_valid = 1'b1;
        in_data  = samp[0][0][0][0];
        res = 1'b1;
        low = 0; quiet = 1'b1;
        while (!in_ready_m && low < 100) begin
            if (peak_valid_m || frame_done_m) quiet = 1'b0;
            low++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("clear_cycles", low, 32);
        chk("quiet_during_clear", int'(quiet), 1);

        // 0x5A sits above lo+15 (lo=0x48), so px0 reports no fine hit.
        run_frame(2, 4, 1'b0);
        run_frame(3, 4, 1'b0);
        run_frame(5, 4, 1'b1);

        // Abort mid-FINE, then a clean frame must behave as if fresh.
        fill(2, 4);
        drive(0, 16 + 5, 4);
        @(negedge clk);
        chk("in_fine_before_abort", int'(in_ready_m), 1);
        res = 1'b0;
        #1;
        chk("outputs_zero_on_reset",
            int'({in_ready_m, peak_valid_m, peak_pixel_m, peak_tof_m, peak_count_m, frame_done_m}), 0);
        @(negedge clk);
        res = 1'b1;
        run_frame(2, 4, 1'b0);

        run_frame(7, 4, 1'b0);
        run_frame(7, 4, 1'b0);

        sel16 = 1'b1;
        run_frame(4, 16, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
